// File: rtl/bus_mux_arb.sv
// bus_mux_arb: fixed-priority N-source bus multiplexer with hold register,
// optional output register and multi-driver conflict capture.
module bus_mux_arb #(
  parameter int W       = 32,
  parameter int N       = 24,
  parameter int REG_OUT = 0,
  parameter int CNT_W   = 8,
  localparam int SW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic [N-1:0]     src_en,
  input  logic [N*W-1:0]   src_data,
  input  logic             err_clr,
  output logic [W-1:0]     bus_out,
  output logic             bus_valid,
  output logic [SW-1:0]    bus_src,
  output logic             conflict,
  output logic             conflict_sticky,
  output logic [N-1:0]     conflict_mask,
  output logic [CNT_W-1:0] conflict_cnt
);
  logic [W-1:0]     win_data, hold_q, bus_d;
  logic [SW-1:0]    win_idx, last_q, src_d;
  logic             any, multi;
  logic             sticky_q, sticky_d;
  logic [N-1:0]     mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    win_data = '0;
    win_idx  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (src_en[i]) begin
        win_data = src_data[i*W +: W];
        win_idx  = SW'(i);
      end
    end
  end

  assign any   = |src_en;
  assign multi = |(src_en & (src_en - N'(1)));
  assign bus_d = any ? win_data : hold_q;
  assign src_d = any ? win_idx : last_q;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      hold_q <= '0;
      last_q <= '0;
    end else if (any) begin
      hold_q <= win_data;
      last_q <= win_idx;
    end
  end

  // A conflict on the same edge as err_clr restarts capture with this offender.
  always_comb begin
    sticky_d = sticky_q;
    mask_d   = mask_q;
    cnt_d    = cnt_q;
    if (multi) begin
      sticky_d = 1'b1;
      mask_d   = (sticky_q && !err_clr) ? mask_q : src_en;
      cnt_d    = err_clr ? CNT_W'(1) : ((&cnt_q) ? cnt_q : cnt_q + CNT_W'(1));
    end else if (err_clr) begin
      sticky_d = 1'b0;
      mask_d   = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      sticky_q <= 1'b0;
      mask_q   <= '0;
      cnt_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
    end
  end

  assign conflict_sticky = sticky_q;
  assign conflict_mask   = mask_q;
  assign conflict_cnt    = cnt_q;

  generate
    if (REG_OUT != 0) begin : g_reg
      logic [W-1:0]  bus_q;
      logic          valid_q, conf_q;
      logic [SW-1:0] src_q;
      always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
          bus_q   <= '0;
          valid_q <= 1'b0;
          src_q   <= '0;
          conf_q  <= 1'b0;
        end else begin
          bus_q   <= bus_d;
          valid_q <= any;
          src_q   <= src_d;
          conf_q  <= multi;
        end
      end
      assign bus_out   = bus_q;
      assign bus_valid = valid_q;
      assign bus_src   = src_q;
      assign conflict  = conf_q;
    end else begin : g_comb
      // Outputs read zero while reset is asserted, even with sources driving.
      assign bus_out   = clear_n ? bus_d : '0;
      assign bus_valid = clear_n & any;
      assign bus_src   = clear_n ? src_d : '0;
      assign conflict  = clear_n & multi;
    end
  endgenerate
endmodule

// File: tb/tb_bus_mux_arb.sv
// tb_bus_mux_arb: directed checks of combinational and registered variants
// driven by the same stimulus.
module tb_bus_mux_arb;
  localparam int W = 32, N = 24, CNT_W = 8, SW = 5;
  logic            clock = 1'b0, clear_n = 1'b0, err_clr = 1'b0;
  logic [N-1:0]    src_en = '0;
  logic [N*W-1:0]  src_data;
  logic [W-1:0]    b0, b1;
  logic            v0, v1, c0, c1, s0, s1;
  logic [SW-1:0]   i0, i1;
  logic [N-1:0]    m0, m1;
  logic [CNT_W-1:0] n0, n1;
  int n_tests = 0, n_fail = 0;

  always #5 clock = ~clock;

  bus_mux_arb #(.W(W), .N(N), .REG_OUT(0), .CNT_W(CNT_W)) u0 (
    .clock(clock), .clear_n(clear_n), .src_en(src_en), .src_data(src_data), .err_clr(err_clr),
    .bus_out(b0), .bus_valid(v0), .bus_src(i0), .conflict(c0),
    .conflict_sticky(s0), .conflict_mask(m0), .conflict_cnt(n0));
  bus_mux_arb #(.W(W), .N(N), .REG_OUT(1), .CNT_W(CNT_W)) u1 (
    .clock(clock), .clear_n(clear_n), .src_en(src_en), .src_data(src_data), .err_clr(err_clr),
    .bus_out(b1), .bus_valid(v1), .bus_src(i1), .conflict(c1),
    .conflict_sticky(s1), .conflict_mask(m1), .conflict_cnt(n1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic [N-1:0] en, input logic [31:0] eb, input logic ev,
                     input logic [31:0] es, input logic ec);
    src_en = en;
    #1;
    check("u0_bus", b0, eb);
    check("u0_valid", {31'd0, v0}, {31'd0, ev});
    check("u0_src", {27'd0, i0}, es);
    check("u0_conf", {31'd0, c0}, {31'd0, ec});
    @(posedge clock);
    #1;
    check("u1_bus", b1, eb);
    check("u1_valid", {31'd0, v1}, {31'd0, ev});
    check("u1_src", {27'd0, i1}, es);
    check("u1_conf", {31'd0, c1}, {31'd0, ec});
  endtask

  task automatic cap(input logic es, input logic [31:0] em, input logic [31:0] ec);
    check("sticky0", {31'd0, s0}, {31'd0, es});
    check("sticky1", {31'd0, s1}, {31'd0, es});
    check("mask0", {8'd0, m0}, em);
    check("mask1", {8'd0, m1}, em);
    check("cnt0", {24'd0, n0}, ec);
    check("cnt1", {24'd0, n1}, ec);
  endtask

  initial begin
    for (int i = 0; i < N; i++) src_data[i*W +: W] = 32'h1000_0000 + i;
    src_data[3*W +: W]  = 32'hDEAD_BEEF;
    src_data[5*W +: W]  = 32'h0000_0055;
    src_data[20*W +: W] = 32'h0000_1000;
    #1;
    check("rst_bus0", b0, 0);
    check("rst_bus1", b1, 0);
    cap(1'b0, 0, 0);
    @(negedge clock);
    @(negedge clock);
    clear_n = 1'b1;
    cyc('0, 0, 1'b0, 0, 1'b0);
    cap(1'b0, 0, 0);
    cyc(24'h000008, 32'hDEAD_BEEF, 1'b1, 3, 1'b0);
    cyc('0, 32'hDEAD_BEEF, 1'b0, 3, 1'b0);
    cyc(24'h100020, 32'h55, 1'b1, 5, 1'b1);
    cap(1'b1, 32'h100020, 1);
    cyc(24'h000006, 32'h1000_0001, 1'b1, 1, 1'b1);
    cap(1'b1, 32'h100020, 2);
    src_en = 24'h000006;
    for (int k = 0; k < 300; k++) @(posedge clock);
    #1;
    cap(1'b1, 32'h100020, 255);
    err_clr = 1'b1;
    cyc('0, 32'h1000_0001, 1'b0, 1, 1'b0);
    cap(1'b0, 0, 0);
    cyc(24'h800001, 32'h1000_0000, 1'b1, 0, 1'b1);
    cap(1'b1, 32'h800001, 1);
    err_clr = 1'b0;
    cyc(24'h400000, 32'h1000_0016, 1'b1, 22, 1'b0);
    #2;
    clear_n = 1'b0;
    #1;
    check("ar_bus0", b0, 0);
    check("ar_bus1", b1, 0);
    check("ar_valid0", {31'd0, v0}, 0);
    check("ar_valid1", {31'd0, v1}, 0);
    check("ar_src0", {27'd0, i0}, 0);
    check("ar_src1", {27'd0, i1}, 0);
    cap(1'b0, 0, 0);
    @(negedge clock);
    clear_n = 1'b1;
    cyc('0, 0, 1'b0, 0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
